// File: rtl/fetch_buffer_if.sv
// Fetch-stage and instruction-memory signals of the prefetch buffer.
// The buffer takes the slave view; whoever drives fetch requests and
// answers memory requests takes the master view.
interface fetch_buffer_if;
    logic        fetch_valid;
    logic        fetch_fence;
    logic        fetch_spec;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_rdata;
    logic        fetch_ready;
    logic        fetch_error;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_error;

    modport slave (
        input  fetch_valid, fetch_fence, fetch_spec, fetch_addr,
        output fetch_rdata, fetch_ready, fetch_error,
        output imem_valid, imem_addr,
        input  imem_ready, imem_rdata, imem_error
    );

    modport master (
        output fetch_valid, fetch_fence, fetch_spec, fetch_addr,
        input  fetch_rdata, fetch_ready, fetch_error,
        input  imem_valid, imem_addr,
        output imem_ready, imem_rdata, imem_error
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: fetches aligned words ahead of the PC into a
// circular halfword queue and hands out 16-bit or 32-bit instructions,
// including 32-bit ones that straddle a word boundary.
module fetch_buffer #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] START_ADDR = 32'h0
) (
    input logic           clock,
    input logic           reset,
    fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO = (AW+1)'(2);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    logic [15:0]      r_q [DEPTH];
    logic [DEPTH-1:0] r_e;
    logic [AW-1:0]    r_rptr, r_wptr;
    logic [AW:0]      r_count;
    logic [31:0]      r_head_addr, r_pf_addr;
    logic             r_skip_lo, r_err_stop;
    state_t           r_state, w_state_next;

    logic             w_flush, w_write, w_issue, w_match, w_ready, w_error;
    logic             w_need2, w_avail, w_err, w_e0, w_e1;
    logic [15:0]      w_hw0, w_hw1;
    logic [AW-1:0]    w_rptr1, w_wptr1;
    logic [AW:0]      w_need, w_pop_n, w_wr_n;
    logic [DEPTH-1:0] w_wr_lo, w_wr_hi;

    assign w_flush = bus.fetch_spec | bus.fetch_fence;
    // A response only lands if it belongs to the current stream.
    assign w_write = (r_state == S_WAIT) & bus.imem_ready & ~w_flush;

    // Read side: head halfword decides whether one or two are needed.
    assign w_rptr1 = r_rptr + PTR_ONE;
    assign w_wptr1 = r_wptr + PTR_ONE;
    assign w_hw0   = r_q[r_rptr];
    assign w_hw1   = r_q[w_rptr1];
    assign w_e0    = r_e[r_rptr];
    assign w_e1    = r_e[w_rptr1];
    assign w_need2 = (w_hw0[1:0] == 2'b11);
    assign w_need  = w_need2 ? CNT_TWO : CNT_ONE;
    assign w_avail = (r_count >= w_need);
    assign w_err   = w_e0 | (w_need2 & w_e1);
    assign w_match = bus.fetch_valid & ~w_flush & (bus.fetch_addr == r_head_addr);
    assign w_ready = w_match & w_avail & ~w_err;
    // A faulting head halfword is reported even before its length is known.
    assign w_error = w_match & ((w_avail & w_err) | ((r_count != '0) & w_e0));

    assign bus.fetch_ready = w_ready;
    assign bus.fetch_error = w_error;
    assign bus.fetch_rdata = !w_ready ? 32'h0 :
                             w_need2  ? {w_hw1, w_hw0} : {16'h0, w_hw0};

    assign w_pop_n = w_ready ? w_need : '0;
    assign w_wr_n  = w_write ? (r_skip_lo ? CNT_ONE : CNT_TWO) : '0;

    // Request only when a whole word fits; reset held low suppresses it.
    assign w_issue = reset & ~w_flush & ~r_err_stop & ((DEPTH_C - r_count) >= CNT_TWO);

    // Per-entry write enables: low half goes to wptr, high half follows it
    // (or takes wptr itself when the low half is skipped after a redirect).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wen
            assign w_wr_lo[gi] = w_write & ~r_skip_lo & (r_wptr == AW'(gi));
            assign w_wr_hi[gi] = w_write & (r_skip_lo ? (r_wptr == AW'(gi))
                                                      : (w_wptr1 == AW'(gi)));
        end
    endgenerate

    // Halfword storage; contents are don't-care until counted as valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_lo[i])      r_q[i] <= bus.imem_rdata[15:0];
            else if (w_wr_hi[i]) r_q[i] <= bus.imem_rdata[31:16];
        end
    end

    // Access-fault flag travelling with each stored halfword.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_e <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_lo[i] | w_wr_hi[i]) r_e[i] <= bus.imem_error;
            end
        end
    end

    // Queue pointers, occupancy and PC tracking; a flush overrides all else.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_err_stop  <= 1'b0;
            r_head_addr <= START_ADDR;
            r_pf_addr   <= {START_ADDR[31:2], 2'b00};
            r_skip_lo   <= START_ADDR[1];
        end else if (w_flush) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_err_stop  <= 1'b0;
            r_head_addr <= bus.fetch_addr;
            r_pf_addr   <= {bus.fetch_addr[31:2], 2'b00};
            r_skip_lo   <= bus.fetch_addr[1];
        end else begin
            r_rptr      <= r_rptr + w_pop_n[AW-1:0];
            r_wptr      <= r_wptr + w_wr_n[AW-1:0];
            r_count     <= r_count + w_wr_n - w_pop_n;
            r_head_addr <= r_head_addr + {{(30-AW){1'b0}}, w_pop_n, 1'b0};
            if (w_write) begin
                r_skip_lo <= 1'b0;
                r_pf_addr <= r_pf_addr + 32'd4;
                if (bus.imem_error) r_err_stop <= 1'b1;
            end
        end
    end

    // Request FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Request FSM: one outstanding request; a flush mid-request drains it.
    always_comb begin
        w_state_next   = r_state;
        bus.imem_valid = 1'b0;
        bus.imem_addr  = r_pf_addr;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    bus.imem_valid = 1'b1;
                    w_state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_flush)              w_state_next = bus.imem_ready ? S_IDLE : S_DROP;
                else if (bus.imem_ready)  w_state_next = S_IDLE;
            end
            S_DROP: begin
                if (bus.imem_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a halfword-address
// queue model of the buffer contents and a word-array memory image.
module tb_fetch_buffer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_buffer_if bif();

    fetch_buffer #(.DEPTH(DEPTH), .START_ADDR(32'h0)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif.slave)
    );

    int errors = 0;
    int checks = 0;

    // Memory image (wraps every 512 bytes) and per-word access faults.
    logic [31:0] mem  [128];
    bit          merr [128];

    // Model: addresses of queued halfwords, in order, plus request state.
    logic [31:0] mq[$];
    logic [31:0] m_head, m_pf, m_req;
    bit          m_skip, m_stop, m_out, m_drop;
    int          m_cnt;
    int          lat_min = 1, lat_max = 1;
    int          cyc;

    // Observations used by the directed literal checks.
    logic [31:0] pop_addr[$], pop_data[$], req_addr[$];
    int          pop_cyc[$], req_cyc[$];
    bit          last_err, last_ready;

    logic [31:0] exp_a_addr [5] = '{32'h0, 32'h4, 32'h6, 32'h8, 32'hA};
    logic [31:0] exp_a_data [5] = '{32'h0041_0093, 32'h0000_4501, 32'h0000_4505,
                                    32'h0000_4501, 32'h0041_0093};

    function automatic logic [15:0] hw(logic [31:0] a);
        logic [31:0] w;
        w = mem[a[8:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit herr(logic [31:0] a);
        return merr[a[8:2]];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_fetch(bit v, bit sp, bit fe, logic [31:0] a);
        bif.fetch_valid = v;
        bif.fetch_spec  = sp;
        bif.fetch_fence = fe;
        bif.fetch_addr  = a;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) begin
            mem[i]  = 32'h0;
            merr[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bif.imem_ready = 1'b0;
        bif.imem_rdata = 32'h0;
        bif.imem_error = 1'b0;
        set_fetch(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_valid",  32'(bif.imem_valid),  32'h0);
        chk("rst_fetch_ready", 32'(bif.fetch_ready), 32'h0);
        chk("rst_fetch_error", 32'(bif.fetch_error), 32'h0);
        chk("rst_fetch_rdata", bif.fetch_rdata,      32'h0);
        mq.delete();
        m_head = 32'h0; m_pf = 32'h0; m_req = 32'h0;
        m_skip = 0; m_stop = 0; m_out = 0; m_drop = 0; m_cnt = 0;
        cyc = 0;
        pop_addr.delete(); pop_data.delete(); pop_cyc.delete();
        req_addr.delete(); req_cyc.delete();
        rst_n = 1'b1;
    endtask

    // One clock cycle: answer memory, compare all outputs, advance model.
    task automatic step();
        bit rdy, flush, iss, cond, rdy_exp, err_exp, e0, e1, av, er;
        int n, need;
        logic [15:0] h0, h1;
        logic [31:0] rd_exp;

        rdy = 1'b0;
        if (m_out) begin
            m_cnt--;
            rdy = (m_cnt == 0);
        end
        bif.imem_ready = rdy;
        bif.imem_rdata = rdy ? mem[m_req[8:2]] : $urandom();
        bif.imem_error = rdy ? merr[m_req[8:2]] : 1'($urandom_range(0, 1));
        #1;

        flush = bif.fetch_spec || bif.fetch_fence;
        n = mq.size();
        iss = !m_out && !flush && !m_stop && ((DEPTH - n) >= 2);
        chk("imem_valid", 32'(bif.imem_valid), 32'(iss));
        if (iss) chk("imem_addr", bif.imem_addr, m_pf);

        cond = bif.fetch_valid && !flush && (bif.fetch_addr == m_head);
        h0 = 16'h0; h1 = 16'h0; e0 = 0; e1 = 0; need = 1;
        if (n >= 1) begin
            h0 = hw(mq[0]);
            e0 = herr(mq[0]);
            need = (h0[1:0] == 2'b11) ? 2 : 1;
        end
        if (n >= 2) begin
            h1 = hw(mq[1]);
            e1 = herr(mq[1]);
        end
        av = (n >= need);
        er = e0 || (need == 2 && e1);
        rdy_exp = cond && av && !er;
        err_exp = cond && ((av && er) || (n >= 1 && e0));
        rd_exp  = !rdy_exp ? 32'h0 : (need == 2) ? {h1, h0} : {16'h0, h0};
        chk("fetch_ready", 32'(bif.fetch_ready), 32'(rdy_exp));
        chk("fetch_error", 32'(bif.fetch_error), 32'(err_exp));
        chk("fetch_rdata", bif.fetch_rdata, rd_exp);

        if (bif.fetch_ready) begin
            pop_addr.push_back(bif.fetch_addr);
            pop_data.push_back(bif.fetch_rdata);
            pop_cyc.push_back(cyc);
            $display("pop   cycle=%0d pc=%08h instr=%08h", cyc, bif.fetch_addr, bif.fetch_rdata);
        end
        if (bif.imem_valid) begin
            req_addr.push_back(bif.imem_addr);
            req_cyc.push_back(cyc);
        end
        last_err   = bif.fetch_error;
        last_ready = bif.fetch_ready;

        if (flush) begin
            mq.delete();
            m_head = bif.fetch_addr;
            m_pf   = {bif.fetch_addr[31:2], 2'b00};
            m_skip = bif.fetch_addr[1];
            m_stop = 0;
            if (m_out) begin
                if (rdy) begin
                    m_out = 0;
                    m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end
        end else begin
            if (rdy_exp) begin
                for (int k = 0; k < need; k++) void'(mq.pop_front());
                m_head += 32'(2 * need);
            end
            if (rdy) begin
                m_out = 0;
                if (m_drop) begin
                    m_drop = 0;
                end else begin
                    if (!m_skip) mq.push_back(m_pf);
                    mq.push_back(m_pf + 32'd2);
                    m_skip = 0;
                    if (merr[m_pf[8:2]]) m_stop = 1;
                    m_pf += 32'd4;
                end
            end
            if (iss) begin
                m_out = 1;
                m_req = m_pf;
                m_cnt = $urandom_range(lat_min, lat_max);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        int pcyc;
        set_fetch(1'b0, 1'b0, 1'b0, 32'h0);

        // Straight-line code: 32-bit, RVC pair, RVC then straddling 32-bit.
        clear_mem();
        mem[0] = 32'h0041_0093;
        mem[1] = 32'h4505_4501;
        mem[2] = 32'h0093_4501;
        mem[3] = 32'h1234_0041;
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (14) begin
            set_fetch(1'b1, 1'b0, 1'b0, m_head);
            step();
        end
        chk("A_first_req_cycle", 32'(req_cyc[0]), 32'd0);
        chk("A_first_req_addr",  req_addr[0],     32'h0);
        chk("A_first_pop_cycle", 32'(pop_cyc[0]), 32'd2);
        chk("A_pop_count_ge5",   32'(pop_addr.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("A_pop_addr", pop_addr[i], exp_a_addr[i]);
            chk("A_pop_data", pop_data[i], exp_a_data[i]);
        end

        // Redirect to 0x106 while the first request is still outstanding.
        clear_mem();
        mem[0]    = 32'h0041_0093;
        mem[8'h41] = 32'h4505_1111;
        lat_min = 3; lat_max = 3;
        do_reset();
        set_fetch(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        set_fetch(1'b1, 1'b1, 1'b0, 32'h106);
        step();
        repeat (12) begin
            set_fetch(1'b1, 1'b0, 1'b0, m_head);
            step();
        end
        chk("B_req_count_ge2",  32'(req_addr.size() >= 2), 32'd1);
        chk("B_second_req_addr", req_addr[1],     32'h104);
        chk("B_second_req_cycle", 32'(req_cyc[1]), 32'd4);
        chk("B_first_pop_addr",  pop_addr[0],     32'h106);
        chk("B_first_pop_data",  pop_data[0],     32'h0000_4505);

        // Access fault on the word at 8 stops prefetch until a redirect.
        clear_mem();
        mem[0] = 32'h4505_4501;
        mem[1] = 32'h4505_4501;
        merr[2] = 1'b1;
        mem[8'h40] = 32'h4505_4501;
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (20) begin
            set_fetch(1'b1, 1'b0, 1'b0, m_head);
            step();
        end
        chk("C_pops_before_fault", 32'(pop_addr.size()), 32'd4);
        chk("C_fault_error",       32'(last_err),        32'd1);
        chk("C_fault_ready",       32'(last_ready),      32'd0);
        chk("C_reqs_stopped",      32'(req_addr.size()), 32'd3);
        set_fetch(1'b1, 1'b1, 1'b0, 32'h100);
        step();
        repeat (6) begin
            set_fetch(1'b1, 1'b0, 1'b0, m_head);
            step();
        end
        chk("C_resume_req_addr", req_addr[3], 32'h100);
        chk("C_resume_pop_addr", pop_addr[4], 32'h100);
        chk("C_resume_pop_data", pop_data[4], 32'h0000_4501);
        chk("C_resume_error",    32'(last_err), 32'd0);

        // Queue fills with no consumer; one 32-bit pop reopens one request.
        clear_mem();
        mem[0] = 32'h0041_0093;
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (20) begin
            set_fetch(1'b0, 1'b0, 1'b0, m_head);
            step();
        end
        chk("D_full_req_count", 32'(req_addr.size()), 32'd4);
        set_fetch(1'b1, 1'b0, 1'b0, m_head);
        pcyc = cyc;
        step();
        repeat (5) begin
            set_fetch(1'b0, 1'b0, 1'b0, m_head);
            step();
        end
        chk("D_refill_req_count", 32'(req_addr.size()), 32'd5);
        chk("D_refill_req_cycle", 32'(req_cyc[4]),      32'(pcyc + 1));
        chk("D_pop_data",         pop_data[0],          32'h0041_0093);

        // Randomized traffic: latencies, redirects, fences, faults, bad PCs.
        for (int i = 0; i < 128; i++) begin
            mem[i]  = $urandom();
            merr[i] = ($urandom_range(0, 19) == 0);
        end
        lat_min = 1; lat_max = 3;
        do_reset();
        repeat (4000) begin
            r = $urandom_range(0, 99);
            if (r < 3)
                set_fetch(1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'($urandom_range(0, 255)) << 1);
            else if (r < 5)
                set_fetch(1'($urandom_range(0, 1)), 1'b0, 1'b1, 32'($urandom_range(0, 255)) << 1);
            else if (r < 8)
                set_fetch(1'b1, 1'b0, 1'b0, m_head + 32'd2);
            else
                set_fetch(r < 80, 1'b0, 1'b0, m_head);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
